// File: rtl/veririscv_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: decides per cycle which stage registers hold or
// take a bubble, covering load-use hazards, taken branches and multi-cycle EX operations.
module veririscv_hazard_ctrl #(
    parameter int RF_AW      = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RF_AW-1:0] id_rs1_addr,
    input  logic [RF_AW-1:0] id_rs2_addr,
    input  logic             id_rs1_rd,
    input  logic             id_rs2_rd,
    input  logic             ex_reg_wen,
    input  logic [RF_AW-1:0] ex_reg_waddr,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    input  logic             mc_done,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mc_busy,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int TW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [0:0]    ST_RUN     = 1'b0;
    localparam logic [0:0]    ST_MC_WAIT = 1'b1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MC_TIMEOUT - 1);

    logic [0:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mc_timeout_q, mc_timeout_d;

    logic in_wait_s;
    logic timeout_hit_s;
    logic mc_hold_s;
    logic lu_s;

    // Hazard detection and stall/flush arbitration (mc_hold > branch > load-use).
    always_comb begin
        in_wait_s     = (state_q == ST_MC_WAIT);
        timeout_hit_s = in_wait_s && (timer_q == TIMER_LAST);
        mc_hold_s     = ((!in_wait_s && ex_mc_start) || in_wait_s) && !mc_done && !timeout_hit_s;
        lu_s          = ex_mem_read && ex_reg_wen && (ex_reg_waddr != {RF_AW{1'b0}}) &&
                        ((id_rs1_rd && (id_rs1_addr == ex_reg_waddr)) ||
                         (id_rs2_rd && (id_rs2_addr == ex_reg_waddr)));
        if_stall = 1'b0;
        id_stall = 1'b0;
        ex_stall = 1'b0;
        if_flush = 1'b0;
        id_flush = 1'b0;
        ex_flush = 1'b0;
        mc_busy  = 1'b0;
        if (!rst) begin
            mc_busy = 1'b0;
        end else begin
            mc_busy = in_wait_s;
            if (mc_hold_s) begin
                if_stall = 1'b1;
                id_stall = 1'b1;
                ex_stall = 1'b1;
                ex_flush = 1'b1;
            end else if (ex_branch_taken && !in_wait_s) begin
                // The ID instruction is squashed, so a pending load-use is moot.
                if_flush = 1'b1;
                id_flush = 1'b1;
            end else if (lu_s) begin
                if_stall = 1'b1;
                id_stall = 1'b1;
                id_flush = 1'b1;
            end else begin
                if_stall = 1'b0;
            end
        end
    end

    // Multi-cycle FSM, timeout timer and saturating stall counter next-state.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        mc_timeout_d = timeout_hit_s;
        case (state_q)
            ST_RUN: begin
                if (ex_mc_start && !mc_done) begin
                    state_d = ST_MC_WAIT;
                    timer_d = {TW{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MC_WAIT: begin
                if (mc_done || timeout_hit_s) begin
                    state_d = ST_RUN;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                timer_d = {TW{1'b0}};
            end
        endcase
        if (if_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            timer_q      <= {TW{1'b0}};
            stall_cnt_q  <= {CNT_W{1'b0}};
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            stall_cnt_q  <= stall_cnt_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    assign mc_timeout = mc_timeout_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_veririscv_hazard_ctrl.sv
// Directed-vector bench for veririscv_hazard_ctrl (MC_TIMEOUT=8, CNT_W=4 to reach saturation).
module tb_veririscv_hazard_ctrl;

    localparam int RF_AW = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [RF_AW-1:0] id_rs1_addr, id_rs2_addr, ex_reg_waddr;
    logic             id_rs1_rd, id_rs2_rd, ex_reg_wen, ex_mem_read;
    logic             ex_branch_taken, ex_mc_start, mc_done;
    logic             if_stall, id_stall, ex_stall, if_flush, id_flush, ex_flush;
    logic             mc_busy, mc_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [5:0]       ctl;

    int n_vec = 0;
    int n_err = 0;

    veririscv_hazard_ctrl #(.RF_AW(RF_AW), .MC_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_rd(id_rs1_rd), .id_rs2_rd(id_rs2_rd),
        .ex_reg_wen(ex_reg_wen), .ex_reg_waddr(ex_reg_waddr), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
        .mc_busy(mc_busy), .mc_timeout(mc_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // {if_stall, id_stall, ex_stall, if_flush, id_flush, ex_flush}
    assign ctl = {if_stall, id_stall, ex_stall, if_flush, id_flush, ex_flush};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_reg_waddr = 5'd0;
        id_rs1_rd = 1'b0; id_rs2_rd = 1'b0; ex_reg_wen = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_mc_start = 1'b0; mc_done = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_reg_wen = 1'b1; ex_reg_waddr = rd;
    endtask

    initial begin
        rst = 1'b0;
        clear_in();
        repeat (3) tick();
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_busy", 32'(mc_busy), 32'd0);
        chk("rst_tmo", 32'(mc_timeout), 32'd0);
        set_load(5'd5); id_rs1_rd = 1'b1; id_rs1_addr = 5'd5; #2;
        chk("rst_forced", 32'(ctl), 32'd0);
        rst = 1'b1; clear_in(); tick();

        // Load-use on rs2
        set_load(5'd5); id_rs2_rd = 1'b1; id_rs2_addr = 5'd5; #2;
        chk("lu_rs2", 32'(ctl), 32'b110010);
        tick(); clear_in(); #2;
        chk("lu_after", 32'(ctl), 32'd0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        // rs1 matches but is not read, rs2 read but differs
        set_load(5'd5); id_rs1_addr = 5'd5; id_rs2_rd = 1'b1; id_rs2_addr = 5'd6; #2;
        chk("lu_rs1_noread", 32'(ctl), 32'd0);
        id_rs1_rd = 1'b1; #1;
        chk("lu_rs1", 32'(ctl), 32'b110010);
        tick();
        ex_mem_read = 1'b0; #2;
        chk("non_load", 32'(ctl), 32'd0);
        chk("lu_cnt2", 32'(stall_cnt), 32'd2);
        clear_in(); tick();

        // Load to x0 never stalls
        set_load(5'd0); id_rs1_rd = 1'b1; id_rs1_addr = 5'd0; #2;
        chk("lu_x0", 32'(ctl), 32'd0);
        tick(); clear_in();
        chk("lu_x0_cnt", 32'(stall_cnt), 32'd2);

        // Branch outranks load-use on x7
        set_load(5'd7); id_rs1_rd = 1'b1; id_rs1_addr = 5'd7; ex_branch_taken = 1'b1; #2;
        chk("br_over_lu", 32'(ctl), 32'b000110);
        tick(); clear_in();
        chk("br_cnt", 32'(stall_cnt), 32'd2);

        // Multi-cycle op with done on the 5th cycle
        ex_mc_start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) begin
                ex_branch_taken = 1'b1; set_load(5'd3); id_rs1_rd = 1'b1; id_rs1_addr = 5'd3;
            end
            #2;
            chk($sformatf("mc_hold_%0d", i), 32'(ctl), 32'b111001);
            tick();
            clear_in(); ex_mc_start = 1'b1;
            chk($sformatf("mc_busy_%0d", i), 32'(mc_busy), 32'd1);
        end
        mc_done = 1'b1; #2;
        chk("mc_done_ctl", 32'(ctl), 32'd0);
        chk("mc_done_busy", 32'(mc_busy), 32'd1);
        tick(); clear_in();
        chk("mc_done_idle", 32'(mc_busy), 32'd0);
        chk("mc_done_tmo", 32'(mc_timeout), 32'd0);
        chk("mc_cnt", 32'(stall_cnt), 32'd6);

        // Same-cycle start and done: no stall
        ex_mc_start = 1'b1; mc_done = 1'b1; #2;
        chk("mc_instant", 32'(ctl), 32'd0);
        tick(); clear_in();
        chk("mc_instant_busy", 32'(mc_busy), 32'd0);

        // Timeout after 8 stall cycles
        ex_mc_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            chk($sformatf("to_hold_%0d", i), 32'(ctl), 32'b111001);
            tick();
            chk($sformatf("to_pulse_%0d", i), 32'(mc_timeout), 32'd0);
        end
        #2;
        chk("to_release", 32'(ctl), 32'd0);
        tick(); clear_in();
        chk("to_pulse", 32'(mc_timeout), 32'd1);
        chk("to_busy", 32'(mc_busy), 32'd0);
        chk("to_cnt", 32'(stall_cnt), 32'd14);
        tick();
        chk("to_pulse_end", 32'(mc_timeout), 32'd0);

        // Counter saturation
        set_load(5'd9); id_rs2_rd = 1'b1; id_rs2_addr = 5'd9;
        repeat (3) tick();
        clear_in();
        chk("cnt_sat", 32'(stall_cnt), 32'd15);

        // Reset in the middle of MC_WAIT
        ex_mc_start = 1'b1;
        repeat (2) tick();
        chk("pre_rst_busy", 32'(mc_busy), 32'd1);
        rst = 1'b0; #2;
        chk("rst_mid_ctl", 32'(ctl), 32'd0);
        chk("rst_mid_busy", 32'(mc_busy), 32'd0);
        tick();
        chk("rst_mid_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_mid_tmo", 32'(mc_timeout), 32'd0);
        rst = 1'b1; clear_in(); #2;
        chk("post_rst_ctl", 32'(ctl), 32'd0);
        chk("post_rst_busy", 32'(mc_busy), 32'd0);
        tick();
        chk("post_rst_tmo", 32'(mc_timeout), 32'd0);
        chk("post_rst_cnt", 32'(stall_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
